// File: rtl/fifo_rd_packer.sv
// Drains an 8-bit FIFO one entry per three cycles and packs PACK_RATIO entries into a wide valid/ready word.
// Optional idle auto-flush is compiled in with `define PACK_TIMEOUT_EN.
module fifo_rd_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PACK_RATIO     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  fifo_empty,
  input  logic [DATA_WIDTH-1:0]                 fifo_dout,
  output logic                                  fifo_ren,
  input  logic                                  flush,
  output logic [DATA_WIDTH*PACK_RATIO-1:0]      out_data,
  output logic [$clog2(PACK_RATIO+1)-1:0]       out_cnt,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  busy
);

  localparam int CW = $clog2(PACK_RATIO + 1);
  localparam int WW = DATA_WIDTH * PACK_RATIO;

  typedef enum logic [1:0] {IDLE, REQ, CAP, HOLD} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_lane_cnt;
  logic [WW-1:0]   r_pack;
  logic            r_fifo_ren;
  logic            r_out_valid;
  logic [WW-1:0]   r_out_data;
  logic [CW-1:0]   r_out_cnt;

  logic            w_out_free;
  logic            w_timeout;

  assign w_out_free = !r_out_valid || out_ready;

`ifdef PACK_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] r_idle_cnt;

  assign w_timeout = (r_state == IDLE) && (r_lane_cnt != '0) &&
                     (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Counts only while a partial word is parked and the FIFO has nothing to offer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (r_state == REQ) begin
      r_idle_cnt <= '0;
    end else if ((r_state == IDLE) && (r_lane_cnt != '0) && fifo_empty && !w_timeout) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lane_cnt  <= '0;
      // NOTE: the pack register is reset too, so a partial word caught by reset can never leak out.
      r_pack      <= '0;
      r_fifo_ren  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cnt   <= '0;
    end else begin
      r_fifo_ren <= 1'b0;
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (flush) begin
            if (r_lane_cnt != '0) r_state <= HOLD;
          end else if (!fifo_empty && (r_lane_cnt < CW'(PACK_RATIO))) begin
            r_state    <= REQ;
            r_fifo_ren <= 1'b1;
          end else if (w_timeout) begin
            r_state <= HOLD;
          end
        end
        REQ: r_state <= CAP;
        CAP: begin
          r_pack[int'(r_lane_cnt)*DATA_WIDTH +: DATA_WIDTH] <= fifo_dout;
          r_lane_cnt <= r_lane_cnt + 1'b1;
          r_state    <= (r_lane_cnt == CW'(PACK_RATIO - 1)) ? HOLD : IDLE;
        end
        HOLD: begin
          // Unfilled lanes are already zero because the pack register is cleared on every load.
          if (w_out_free) begin
            r_out_data  <= r_pack;
            r_out_cnt   <= r_lane_cnt;
            r_out_valid <= 1'b1;
            r_lane_cnt  <= '0;
            r_pack      <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fifo_ren  = r_fifo_ren;
  assign out_data  = r_out_data;
  assign out_cnt   = r_out_cnt;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != IDLE) || (r_lane_cnt != '0) || r_out_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a queue-based FIFO model feeds the DUT, expected words are built from pushed bytes.
module tb_fifo_rd_packer;
  localparam int DW = 8;
  localparam int PR = 4;
  localparam int TO = 8;
  localparam int CW = $clog2(PR + 1);
  localparam int WW = DW * PR;

  typedef struct packed {
    logic [WW-1:0] data;
    logic [CW-1:0] cnt;
  } word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_ren;
  logic          flush;
  logic [WW-1:0] out_data;
  logic [CW-1:0] out_cnt;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  logic          push_en;
  logic [DW-1:0] push_data;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] lanes[$];
  word_t         exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int ren_count = 0;

  always #5 clk = ~clk;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_ren(fifo_ren), .flush(flush), .out_data(out_data), .out_cnt(out_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // FIFO model: registered empty flag and read data one cycle after the read.
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_empty <= 1'b1;
      fifo_dout  <= '0;
    end else begin
      if (fifo_ren) begin
        check("no_read_when_empty", 64'(fq.size() != 0), 64'd1);
        if (fq.size() != 0) fifo_dout <= fq.pop_front();
      end
      if (push_en) fq.push_back(push_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Read-pulse spacing monitor.
  int gap = 99;
  always @(negedge clk) begin
    if (rst) begin
      gap = 99;
    end else if (fifo_ren) begin
      ren_count++;
      check("ren_spacing_ge2", 64'(gap >= 2), 64'd1);
      gap = 0;
    end else begin
      gap++;
    end
  end

  // Output monitor: pops the scoreboard on every handshake and checks stability under backpressure.
  logic          prev_stall = 1'b0;
  logic [WW-1:0] prev_data;
  logic [CW-1:0] prev_cnt;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 64'(out_valid), 64'd1);
        check("stall_data_stable", 64'(out_data), 64'(prev_data));
        check("stall_cnt_stable", 64'(out_cnt), 64'(prev_cnt));
      end
      if (out_valid && out_ready) begin
        check("word_was_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          word_t w;
          w = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(w.data));
          check("out_cnt", 64'(out_cnt), 64'(w.cnt));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_cnt   = out_cnt;
    end
  end

  function automatic word_t build_word();
    word_t w;
    w.data = '0;
    for (int i = 0; i < lanes.size(); i++) w.data |= WW'(lanes[i]) << (DW * i);
    w.cnt = CW'(lanes.size());
    return w;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    push_en   = 1'b1;
    push_data = b;
    lanes.push_back(b);
    if (lanes.size() == PR) begin
      exp_q.push_back(build_word());
      lanes.delete();
    end
    step(1);
    push_en = 1'b0;
  endtask

  task automatic expect_partial();
    if (lanes.size() != 0) begin
      exp_q.push_back(build_word());
      lanes.delete();
    end
  endtask

  task automatic wait_fifo_drained();
    int i;
    for (i = 0; i < 400; i++) begin
      if (fq.size() == 0 && fifo_empty) break;
      step(1);
    end
    check("fifo_drain_bound", 64'(i < 400), 64'd1);
    step(6);
  endtask

  task automatic do_flush();
    int i;
    expect_partial();
    wait_fifo_drained();
    flush = 1'b1;
    for (i = 0; i < 200; i++) begin
      step(1);
      if (!busy) break;
    end
    flush = 1'b0;
    check("flush_busy_clears", 64'(busy), 64'd0);
  endtask

  task automatic wait_out_drained(input string name);
    int i;
    for (i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      step(1);
    end
    check(name, 64'(exp_q.size() == 0 && !out_valid), 64'd1);
  endtask

  initial begin
    int base;
    int i;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; push_en = 1'b0; push_data = '0;
    step(3);
    check("rst_ren", 64'(fifo_ren), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // Reset in the middle of an active read.
    push_byte(8'h55);
    push_byte(8'h66);
    for (i = 0; i < 20; i++) begin
      if (fifo_ren) break;
      step(1);
    end
    check("req_seen_before_reset", 64'(fifo_ren), 64'd1);
    rst = 1'b1;
    lanes.delete();
    exp_q.delete();
    step(2);
    check("midrst_ren", 64'(fifo_ren), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_data", 64'(out_data), 64'd0);
    check("midrst_cnt", 64'(out_cnt), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    step(1);

    // Full pack from lane 0.
    base = ren_count;
    foreach (lanes[k]) lanes.delete(k);
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    wait_out_drained("full_pack_done");
    check("full_pack_reads", 64'(ren_count - base), 64'd4);

    // Backpressure: two words, second parked in HOLD.
    base = ren_count;
    out_ready = 1'b0;
    for (int b = 1; b <= 8; b++) push_byte(DW'(b));
    step(40);
    check("bp_reads", 64'(ren_count - base), 64'd8);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_first_data", 64'(out_data), 64'h04030201);
    check("bp_first_cnt", 64'(out_cnt), 64'd4);
    out_ready = 1'b1;
    step(1);
    check("bp_second_valid", 64'(out_valid), 64'd1);
    check("bp_second_data", 64'(out_data), 64'h08070605);
    wait_out_drained("bp_done");
    check("bp_no_extra_reads", 64'(ren_count - base), 64'd8);

    // Flush a two-entry partial, then a flush with nothing pending.
    push_byte(8'hAA);
    push_byte(8'hBB);
    do_flush();
    wait_out_drained("flush_partial_done");
    do_flush();
    step(5);
    check("empty_flush_no_word", 64'(out_valid), 64'd0);

    // Single entry in the FIFO.
    base = ren_count;
    push_byte(8'h5A);
    step(7);
    check("single_reads", 64'(ren_count - base), 64'd1);
    check("single_busy", 64'(busy), 64'd1);
    check("single_no_word", 64'(out_valid), 64'd0);
    do_flush();
    wait_out_drained("single_flush_done");

    // Idle partial: auto-flush when enabled, parked until flush otherwise.
    push_byte(8'h10); push_byte(8'h20); push_byte(8'h30);
`ifdef PACK_TIMEOUT_EN
    expect_partial();
    wait_fifo_drained();
    wait_out_drained("timeout_word_done");
`else
    wait_fifo_drained();
    for (i = 0; i < 40; i++) begin
      if (out_valid) break;
      step(1);
    end
    check("no_timeout_no_word", 64'(out_valid), 64'd0);
    check("no_timeout_busy", 64'(busy), 64'd1);
    do_flush();
    wait_out_drained("partial_flush_done");
`endif

    // Randomized streams with random backpressure, each closed with a flush.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(5, 20));
      for (int j = 0; j < n; j++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        push_byte(DW'($urandom));
        repeat ($urandom_range(0, 2)) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step(1);
        end
      end
      out_ready = 1'b1;
      do_flush();
      wait_out_drained("random_round_done");
    end

    step(5);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
Downstream consumer of the 8-bit synchronous FIFO (fifo_dut). It drains the FIFO through its ren/empty/dout interface and packs PACK_RATIO consecutive entries into one wide word. Packed words go out on a valid/ready stream. The block also supports explicit flush of a partially filled word.

Parameters:
DATA_WIDTH, 8, width of one FIFO entry
PACK_RATIO, 4, FIFO entries per output word; legal values 2..16
TIMEOUT_CYCLES, 64, idle cycles before auto-flush; used only with PACK_TIMEOUT_EN

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  reset; one clock; reset is synchronous and active-high
fifo_empty  input  1  FIFO empty flag (registered inside FIFO, lags pointer state)
fifo_dout  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read
fifo_ren  output  1  FIFO read enable, single-cycle pulse
flush  input  1  request emission of the current partial word
out_data  output  DATA_WIDTH*PACK_RATIO  packed word; entry 0 in LSBs
out_cnt  output  $clog2(PACK_RATIO+1)  number of valid entries in out_data (1..PACK_RATIO)
out_valid  output  1  out_data/out_cnt valid
out_ready  input  1  downstream accepts when out_valid && out_ready
busy  output  1  high when not in IDLE, or when lane count != 0, or when out_valid is high

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; fifo_ren=0, out_valid=0, out_data=0, out_cnt=0, busy=0; lane count=0; pack register=0. Reset overrides all other activity mid-operation; the partial word is discarded.
- FSM states: IDLE, REQ, CAP, HOLD.
  - IDLE -> REQ: when fifo_empty=0, lane count < PACK_RATIO and flush=0.
  - IDLE -> HOLD: on flush=1 with lane count > 0.
  - IDLE stays IDLE: on flush=1 with lane count = 0 (no output).
  - REQ: fifo_ren=1 for exactly this cycle; always -> CAP.
  - CAP: sample fifo_dout into lane[lane count]; increment lane count.
    - If lane count becomes PACK_RATIO -> HOLD.
    - Otherwise -> IDLE.
- fifo_ren is never asserted in IDLE, CAP or HOLD. This gives one read per 3 cycles minimum. Because of that spacing, fifo_empty sampled in IDLE always reflects all prior reads, so the block never reads an empty FIFO.
- HOLD loads the output register when it is free:
  - Output register is free when out_valid=0, or out_valid=1 && out_ready=1 in the same cycle.
  - On load: out_data = pack register with unfilled lanes zeroed; out_cnt = lane count; out_valid=1; lane count=0; pack register cleared.
  - After load -> IDLE.
  - If the output register is not free, stay in HOLD. No FIFO reads occur while in HOLD.
- Output handshake:
  - out_data and out_cnt are stable while out_valid && !out_ready.
  - out_valid drops the cycle after acceptance unless a new load happens in that same cycle.
  - Back-to-back words are allowed.
- Flush:
  - Sampled only in IDLE. If flush is asserted during REQ or CAP, it is ignored; the requester must hold flush until busy=0.
  - A flush with lane count 0 produces no output.
- Wrap: lane index restarts at 0 after every load. The FIFO's own wrap behaviour is invisible to this block.
- Latency: the first entry visible in the FIFO reaches out_data at minimum 3*PACK_RATIO+1 cycles after fifo_empty deasserts, given out_ready=1.

Optional Feature:
PACK_TIMEOUT_EN
- Defined: a counter increments in IDLE while lane count > 0 and fifo_empty=1. It clears on any REQ or on reset. When it reaches TIMEOUT_CYCLES-1, the FSM goes IDLE -> HOLD exactly as for flush.
- Not defined: no counter; partial words leave only via flush. The TIMEOUT_CYCLES parameter is present but unused.

Test Plan:
- Reset: hold rst=1 for 2 cycles during an active REQ -> fifo_ren=0, out_valid=0, out_data=0, out_cnt=0, busy=0 at the next edge; a subsequent full pack starts from lane 0.
- Full pack: FIFO preloaded with 0x11,0x22,0x33,0x44, out_ready=1 -> one word out_data=0x44332211, out_cnt=4; exactly 4 fifo_ren pulses, each separated by at least 2 low cycles.
- Backpressure: 8 entries 0x01..0x08, out_ready=0 -> first word 0x04030201 held stable; block stops in HOLD after 4 more reads. Raise out_ready -> second word 0x08070605 follows on the next cycle, with no extra reads.
- Flush: 2 entries 0xAA,0xBB then FIFO empty, pulse flush in IDLE -> out_data=0x0000BBAA, out_cnt=2. A second flush with lane count 0 produces no out_valid.
- Empty boundary: FIFO holding 1 entry -> exactly one fifo_ren; no further reads while fifo_empty=1; lane count=1, busy=1.
- PACK_TIMEOUT_EN with TIMEOUT_CYCLES=8: 3 entries 0x10,0x20,0x30 then FIFO empty -> after 8 idle cycles, out_data=0x00302010, out_cnt=3. Without the macro: no output until flush.
